// File: rtl/gemm_uop_seq.sv
// GEMM loop sequencer for the uop-fetch stage: walks outer/inner/uop loops,
// issues uop memory reads and emits each uop with its loop-scaled offsets.
module gemm_uop_seq #(
    parameter int UOP_WIDTH      = 32,
    parameter int UOP_ADDR_WIDTH = 13,
    parameter int LOOP_WIDTH     = 14,
    parameter int A_IDX_WIDTH    = 12,
    parameter int I_IDX_WIDTH    = 12,
    parameter int W_IDX_WIDTH    = 11
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        insn_valid,
    output logic                        insn_ready,
    input  logic                        insn_reset,
    input  logic [UOP_ADDR_WIDTH-1:0]   uop_bgn,
    input  logic [UOP_ADDR_WIDTH:0]     uop_end,
    input  logic [LOOP_WIDTH-1:0]       iter_out,
    input  logic [LOOP_WIDTH-1:0]       iter_in,
    input  logic [A_IDX_WIDTH-2:0]      dst_factor_out,
    input  logic [A_IDX_WIDTH-2:0]      dst_factor_in,
    input  logic [I_IDX_WIDTH-2:0]      src_factor_out,
    input  logic [I_IDX_WIDTH-2:0]      src_factor_in,
    input  logic [W_IDX_WIDTH-2:0]      wgt_factor_out,
    input  logic [W_IDX_WIDTH-2:0]      wgt_factor_in,
    input  logic                        u_stall,
    output logic                        uop_rd_en,
    output logic [UOP_ADDR_WIDTH-1:0]   uop_rd_addr,
    input  logic [UOP_WIDTH-1:0]        uop_rd_data,
    output logic                        u_valid,
    output logic                        u_last,
    output logic [UOP_WIDTH-1:0]        uop,
    output logic                        u_reset,
    output logic [A_IDX_WIDTH-2:0]      u_dst_offset_out,
    output logic [A_IDX_WIDTH-2:0]      u_dst_offset_in,
    output logic [I_IDX_WIDTH-2:0]      u_src_offset_out,
    output logic [I_IDX_WIDTH-2:0]      u_src_offset_in,
    output logic [W_IDX_WIDTH-2:0]      u_wgt_offset_out,
    output logic [W_IDX_WIDTH-2:0]      u_wgt_offset_in,
    output logic                        insn_done,
    output logic [1:0]                  dbg_state
);

    localparam int DW = A_IDX_WIDTH - 1;
    localparam int IW = I_IDX_WIDTH - 1;
    localparam int WW = W_IDX_WIDTH - 1;

    localparam logic [UOP_ADDR_WIDTH:0]   END_ONE  = {{UOP_ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [UOP_ADDR_WIDTH-1:0] ADDR_ONE = {{(UOP_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LOOP_WIDTH-1:0]     ITER_ONE = {{(LOOP_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_EMPTY = 2'd3
    } state_e;

    // Instruction handshake: an instruction transfers on a posedge where
    // insn_valid && insn_ready; insn_ready is high only in IDLE, and an
    // offered instruction stays pending (not consumed) while the sequencer is busy.

    state_e                    state_q, state_d;
    logic [UOP_ADDR_WIDTH-1:0] u_q, u_d;
    logic [LOOP_WIDTH-1:0]     i0_q, i0_d;
    logic [LOOP_WIDTH-1:0]     i1_q, i1_d;
    logic [UOP_ADDR_WIDTH-1:0] bgn_q, bgn_d;
    logic [UOP_ADDR_WIDTH:0]   end_q, end_d;
    logic [LOOP_WIDTH-1:0]     iter_out_q, iter_out_d;
    logic [LOOP_WIDTH-1:0]     iter_in_q, iter_in_d;
    logic                      reset_q, reset_d;

    logic [DW-1:0] dst_fo_q, dst_fo_d, dst_fi_q, dst_fi_d;
    logic [IW-1:0] src_fo_q, src_fo_d, src_fi_q, src_fi_d;
    logic [WW-1:0] wgt_fo_q, wgt_fo_d, wgt_fi_q, wgt_fi_d;

    logic [DW-1:0] dst_ao_q, dst_ao_d, dst_ai_q, dst_ai_d;
    logic [IW-1:0] src_ao_q, src_ao_d, src_ai_q, src_ai_d;
    logic [WW-1:0] wgt_ao_q, wgt_ao_d, wgt_ai_q, wgt_ai_d;

    // Offsets staged one cycle so they meet uop_rd_data from the same read.
    logic [DW-1:0] dst_oo_q, dst_oo_d, dst_oi_q, dst_oi_d;
    logic [IW-1:0] src_oo_q, src_oo_d, src_oi_q, src_oi_d;
    logic [WW-1:0] wgt_oo_q, wgt_oo_d, wgt_oi_q, wgt_oi_d;

    logic valid_q, valid_d;
    logic step;
    logic last_u, last_i1, last_i0;
    logic is_empty;

    always_comb begin
        state_d    = state_q;
        u_d        = u_q;
        i0_d       = i0_q;
        i1_d       = i1_q;
        bgn_d      = bgn_q;
        end_d      = end_q;
        iter_out_d = iter_out_q;
        iter_in_d  = iter_in_q;
        reset_d    = reset_q;
        dst_fo_d   = dst_fo_q;
        dst_fi_d   = dst_fi_q;
        src_fo_d   = src_fo_q;
        src_fi_d   = src_fi_q;
        wgt_fo_d   = wgt_fo_q;
        wgt_fi_d   = wgt_fi_q;
        dst_ao_d   = dst_ao_q;
        dst_ai_d   = dst_ai_q;
        src_ao_d   = src_ao_q;
        src_ai_d   = src_ai_q;
        wgt_ao_d   = wgt_ao_q;
        wgt_ai_d   = wgt_ai_q;
        dst_oo_d   = dst_oo_q;
        dst_oi_d   = dst_oi_q;
        src_oo_d   = src_oo_q;
        src_oi_d   = src_oi_q;
        wgt_oo_d   = wgt_oo_q;
        wgt_oi_d   = wgt_oi_q;

        insn_ready = (state_q == S_IDLE);
        step       = (state_q == S_RUN) && !u_stall;
        valid_d    = step;
        last_u     = ({1'b0, u_q} == (end_q - END_ONE));
        last_i1    = (i1_q == (iter_in_q - ITER_ONE));
        last_i0    = (i0_q == (iter_out_q - ITER_ONE));
        is_empty   = (iter_out == '0) || (iter_in == '0) || (uop_end <= {1'b0, uop_bgn});

        case (state_q)
            S_IDLE: begin
                if (insn_valid) begin
                    bgn_d      = uop_bgn;
                    end_d      = uop_end;
                    iter_out_d = iter_out;
                    iter_in_d  = iter_in;
                    reset_d    = insn_reset;
                    dst_fo_d   = dst_factor_out;
                    dst_fi_d   = dst_factor_in;
                    src_fo_d   = src_factor_out;
                    src_fi_d   = src_factor_in;
                    wgt_fo_d   = wgt_factor_out;
                    wgt_fi_d   = wgt_factor_in;
                    u_d        = uop_bgn;
                    i0_d       = '0;
                    i1_d       = '0;
                    dst_ao_d   = '0;
                    dst_ai_d   = '0;
                    src_ao_d   = '0;
                    src_ai_d   = '0;
                    wgt_ao_d   = '0;
                    wgt_ai_d   = '0;
                    state_d    = is_empty ? S_EMPTY : S_RUN;
                end
            end
            S_RUN: begin
                if (step) begin
                    dst_oo_d = dst_ao_q;
                    dst_oi_d = dst_ai_q;
                    src_oo_d = src_ao_q;
                    src_oi_d = src_ai_q;
                    wgt_oo_d = wgt_ao_q;
                    wgt_oi_d = wgt_ai_q;
                    u_d      = u_q + ADDR_ONE;
                    if (last_u) begin
                        u_d = bgn_q;
                        if (last_i1) begin
                            i1_d     = '0;
                            dst_ai_d = '0;
                            src_ai_d = '0;
                            wgt_ai_d = '0;
                            i0_d     = i0_q + ITER_ONE;
                            dst_ao_d = dst_ao_q + dst_fo_q;
                            src_ao_d = src_ao_q + src_fo_q;
                            wgt_ao_d = wgt_ao_q + wgt_fo_q;
                            if (last_i0) begin
                                state_d = S_DRAIN;
                            end
                        end else begin
                            i1_d     = i1_q + ITER_ONE;
                            dst_ai_d = dst_ai_q + dst_fi_q;
                            src_ai_d = src_ai_q + src_fi_q;
                            wgt_ai_d = wgt_ai_q + wgt_fi_q;
                        end
                    end
                end
            end
            S_DRAIN: state_d = S_IDLE;
            S_EMPTY: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            u_q        <= '0;
            i0_q       <= '0;
            i1_q       <= '0;
            bgn_q      <= '0;
            end_q      <= '0;
            iter_out_q <= '0;
            iter_in_q  <= '0;
            reset_q    <= 1'b0;
            dst_fo_q   <= '0;
            dst_fi_q   <= '0;
            src_fo_q   <= '0;
            src_fi_q   <= '0;
            wgt_fo_q   <= '0;
            wgt_fi_q   <= '0;
            dst_ao_q   <= '0;
            dst_ai_q   <= '0;
            src_ao_q   <= '0;
            src_ai_q   <= '0;
            wgt_ao_q   <= '0;
            wgt_ai_q   <= '0;
            dst_oo_q   <= '0;
            dst_oi_q   <= '0;
            src_oo_q   <= '0;
            src_oi_q   <= '0;
            wgt_oo_q   <= '0;
            wgt_oi_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            u_q        <= u_d;
            i0_q       <= i0_d;
            i1_q       <= i1_d;
            bgn_q      <= bgn_d;
            end_q      <= end_d;
            iter_out_q <= iter_out_d;
            iter_in_q  <= iter_in_d;
            reset_q    <= reset_d;
            dst_fo_q   <= dst_fo_d;
            dst_fi_q   <= dst_fi_d;
            src_fo_q   <= src_fo_d;
            src_fi_q   <= src_fi_d;
            wgt_fo_q   <= wgt_fo_d;
            wgt_fi_q   <= wgt_fi_d;
            dst_ao_q   <= dst_ao_d;
            dst_ai_q   <= dst_ai_d;
            src_ao_q   <= src_ao_d;
            src_ai_q   <= src_ai_d;
            wgt_ao_q   <= wgt_ao_d;
            wgt_ai_q   <= wgt_ai_d;
            dst_oo_q   <= dst_oo_d;
            dst_oi_q   <= dst_oi_d;
            src_oo_q   <= src_oo_d;
            src_oi_q   <= src_oi_d;
            wgt_oo_q   <= wgt_oo_d;
            wgt_oi_q   <= wgt_oi_d;
            valid_q    <= valid_d;
        end
    end

    // DRAIN always carries the last uop, whose read was issued by the final RUN step.
    assign uop_rd_en        = step;
    assign uop_rd_addr      = u_q;
    assign uop              = uop_rd_data;
    assign u_valid          = valid_q;
    assign u_last           = (state_q == S_DRAIN);
    assign insn_done        = (state_q == S_DRAIN) || (state_q == S_EMPTY);
    assign u_reset          = reset_q;
    assign u_dst_offset_out = dst_oo_q;
    assign u_dst_offset_in  = dst_oi_q;
    assign u_src_offset_out = src_oo_q;
    assign u_src_offset_in  = src_oi_q;
    assign u_wgt_offset_out = wgt_oo_q;
    assign u_wgt_offset_in  = wgt_oi_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_gemm_uop_seq.sv
// Bench for gemm_uop_seq: a uop memory model plus a nested-loop reference
// that lists every expected output in order for a scoreboard to consume.
module tb_gemm_uop_seq;

    localparam int UW = 32;
    localparam int AW = 13;
    localparam int LW = 14;
    localparam int DW = 11;
    localparam int IW = 11;
    localparam int WW = 10;

    typedef struct packed {
        logic [UW-1:0] uop;
        logic [DW-1:0] dst_o;
        logic [DW-1:0] dst_i;
        logic [IW-1:0] src_o;
        logic [IW-1:0] src_i;
        logic [WW-1:0] wgt_o;
        logic [WW-1:0] wgt_i;
        logic          last;
        logic          done;
        logic          rflag;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          insn_valid;
    logic          insn_ready;
    logic          insn_reset;
    logic [AW-1:0] uop_bgn;
    logic [AW:0]   uop_end;
    logic [LW-1:0] iter_out, iter_in;
    logic [DW-1:0] dst_factor_out, dst_factor_in;
    logic [IW-1:0] src_factor_out, src_factor_in;
    logic [WW-1:0] wgt_factor_out, wgt_factor_in;
    logic          u_stall;
    logic          uop_rd_en;
    logic [AW-1:0] uop_rd_addr;
    logic [UW-1:0] uop_rd_data;
    logic          u_valid, u_last, u_reset, insn_done;
    logic [UW-1:0] uop;
    logic [DW-1:0] u_dst_offset_out, u_dst_offset_in;
    logic [IW-1:0] u_src_offset_out, u_src_offset_in;
    logic [WW-1:0] u_wgt_offset_out, u_wgt_offset_in;
    logic [1:0]    dbg_state;

    gemm_uop_seq dut (
        .clk(clk), .rst(rst),
        .insn_valid(insn_valid), .insn_ready(insn_ready), .insn_reset(insn_reset),
        .uop_bgn(uop_bgn), .uop_end(uop_end), .iter_out(iter_out), .iter_in(iter_in),
        .dst_factor_out(dst_factor_out), .dst_factor_in(dst_factor_in),
        .src_factor_out(src_factor_out), .src_factor_in(src_factor_in),
        .wgt_factor_out(wgt_factor_out), .wgt_factor_in(wgt_factor_in),
        .u_stall(u_stall), .uop_rd_en(uop_rd_en), .uop_rd_addr(uop_rd_addr),
        .uop_rd_data(uop_rd_data), .u_valid(u_valid), .u_last(u_last), .uop(uop),
        .u_reset(u_reset),
        .u_dst_offset_out(u_dst_offset_out), .u_dst_offset_in(u_dst_offset_in),
        .u_src_offset_out(u_src_offset_out), .u_src_offset_in(u_src_offset_in),
        .u_wgt_offset_out(u_wgt_offset_out), .u_wgt_offset_in(u_wgt_offset_in),
        .insn_done(insn_done), .dbg_state(dbg_state)
    );

    exp_t          exp_q[$];
    int            vcyc_q[$];
    int            done_q[$];
    int            rd_cnt;
    int            cyc   = 0;
    int            n_vec = 0;
    int            n_err = 0;
    logic [UW-1:0] mem [0:(1<<AW)-1];
    exp_t          sb_got, sb_exp;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    // Synchronous uop memory: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (uop_rd_en) uop_rd_data <= mem[uop_rd_addr];
    end

    // ---------------- monitor + scoreboard ----------------
    always @(negedge clk) begin
        if (uop_rd_en) rd_cnt++;
        if (insn_done) done_q.push_back(cyc);
        if (u_valid) begin
            vcyc_q.push_back(cyc);
            sb_got = {uop, u_dst_offset_out, u_dst_offset_in, u_src_offset_out,
                      u_src_offset_in, u_wgt_offset_out, u_wgt_offset_in,
                      u_last, insn_done, u_reset};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_output: got %h at cycle %0d, required no output", sb_got, cyc);
            end else begin
                sb_exp = exp_q.pop_front();
                if (sb_got !== sb_exp) begin
                    n_err++;
                    $display("FAIL sb_output: cycle %0d got %h, required %h", cyc, sb_got, sb_exp);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic build_exp(input int bgn, input int end_, input int io, input int ii,
                             input int fdo, input int fdi, input int fso, input int fsi,
                             input int fwo, input int fwi, input bit rf, output int n);
        exp_t e;
        n = 0;
        for (int i0 = 0; i0 < io; i0++) begin
            for (int i1 = 0; i1 < ii; i1++) begin
                for (int a = bgn; a < end_; a++) begin
                    e.uop   = mem[a];
                    e.dst_o = DW'(i0 * fdo);
                    e.dst_i = DW'(i1 * fdi);
                    e.src_o = IW'(i0 * fso);
                    e.src_i = IW'(i1 * fsi);
                    e.wgt_o = WW'(i0 * fwo);
                    e.wgt_i = WW'(i1 * fwi);
                    e.last  = (i0 == io - 1) && (i1 == ii - 1) && (a == end_ - 1);
                    e.done  = e.last;
                    e.rflag = rf;
                    exp_q.push_back(e);
                    n++;
                end
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive_fields(input int bgn, input int end_, input int io, input int ii,
                                input int fdo, input int fdi, input int fso, input int fsi,
                                input int fwo, input int fwi, input bit rf);
        uop_bgn        = AW'(bgn);
        uop_end        = (AW+1)'(end_);
        iter_out       = LW'(io);
        iter_in        = LW'(ii);
        dst_factor_out = DW'(fdo);
        dst_factor_in  = DW'(fdi);
        src_factor_out = IW'(fso);
        src_factor_in  = IW'(fsi);
        wgt_factor_out = WW'(fwo);
        wgt_factor_in  = WW'(fwi);
        insn_reset     = rf;
    endtask

    // Returns the cycle in which the instruction was presented and taken.
    task automatic send_insn(input int bgn, input int end_, input int io, input int ii,
                             input int fdo, input int fdi, input int fso, input int fsi,
                             input int fwo, input int fwi, input bit rf, output int t_acc);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!insn_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (!insn_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_ready_timeout: insn_ready=%b, required 1", insn_ready);
        end
        drive_fields(bgn, end_, io, ii, fdo, fdi, fso, fsi, fwo, fwi, rf);
        insn_valid = 1'b1;
        @(posedge clk);
        #1;
        t_acc      = cyc - 1;
        insn_valid = 1'b0;
    endtask

    task automatic wait_ready(output int t);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!insn_ready && k < 1000);
        t = cyc;
        if (!insn_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: insn_ready=%b after %0d cycles, required 1", insn_ready, k);
        end
    endtask

    task automatic clear_obs();
        vcyc_q.delete();
        done_q.delete();
        rd_cnt = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({insn_ready, u_valid, u_last, uop_rd_en, insn_done, u_reset} !== 6'b100000) begin
            n_err++;
            $display("FAIL reset_ctrl: got rdy/val/last/rden/done/rst=%b, required 100000",
                     {insn_ready, u_valid, u_last, uop_rd_en, insn_done, u_reset});
        end
        n_vec++;
        if ({u_dst_offset_out, u_dst_offset_in, u_src_offset_out, u_src_offset_in,
             u_wgt_offset_out, u_wgt_offset_in} !== '0) begin
            n_err++;
            $display("FAIL reset_offsets: got %h, required 0",
                     {u_dst_offset_out, u_dst_offset_in, u_src_offset_out, u_src_offset_in,
                      u_wgt_offset_out, u_wgt_offset_in});
        end
        rst = 1'b0;
        clear_obs();
    endtask

    task automatic test_basic();
        int t, tr, n;
        bit ok;
        clear_obs();
        build_exp(4, 6, 2, 3, 16, 1, 8, 2, 0, 4, 1'b0, n);
        send_insn(4, 6, 2, 3, 16, 1, 8, 2, 0, 4, 1'b0, t);
        wait_ready(tr);
        ok = (vcyc_q.size() == n);
        for (int k = 0; k < vcyc_q.size(); k++) if (vcyc_q[k] != t + 2 + k) ok = 1'b0;
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL basic_valid_cycles: got %0d outputs starting cycle %0d, required %0d consecutive from %0d",
                     vcyc_q.size(), (vcyc_q.size() > 0) ? vcyc_q[0] : -1, n, t + 2);
        end
        n_vec++;
        if (done_q.size() != 1 || done_q[0] != t + n + 1) begin
            n_err++;
            $display("FAIL basic_done: got %0d pulses first at %0d, required 1 at %0d",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, t + n + 1);
        end
        n_vec++;
        if (tr != t + n + 2) begin
            n_err++;
            $display("FAIL basic_ready: got ready at %0d, required %0d", tr, t + n + 2);
        end
        n_vec++;
        if (rd_cnt != n || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL basic_reads: got %0d reads, %0d unconsumed, required %0d reads, 0 left",
                     rd_cnt, exp_q.size(), n);
        end
    endtask

    task automatic test_stall();
        int t, tr, n, want;
        bit ok;
        clear_obs();
        build_exp(4, 6, 2, 3, 16, 1, 8, 2, 0, 4, 1'b0, n);
        send_insn(4, 6, 2, 3, 16, 1, 8, 2, 0, 4, 1'b0, t);
        // Stall is held for three cycles right after the second read.
        repeat (2) @(posedge clk);
        #1 u_stall = 1'b1;
        repeat (3) @(posedge clk);
        #1 u_stall = 1'b0;
        wait_ready(tr);
        ok = (vcyc_q.size() == n);
        for (int k = 0; k < vcyc_q.size(); k++) begin
            want = (k < 2) ? (t + 2 + k) : (t + 5 + k);
            if (vcyc_q[k] != want) ok = 1'b0;
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL stall_valid_cycles: got %0d outputs, third at %0d, required %0d with third at %0d",
                     vcyc_q.size(), (vcyc_q.size() > 2) ? vcyc_q[2] : -1, n, t + 7);
        end
        n_vec++;
        if (done_q.size() != 1 || done_q[0] != t + n + 4 || rd_cnt != n) begin
            n_err++;
            $display("FAIL stall_done: got %0d pulses at %0d, %0d reads, required 1 at %0d, %0d reads",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, rd_cnt, t + n + 4, n);
        end
    endtask

    task automatic test_empty();
        int t, tr, n;
        for (int c = 0; c < 2; c++) begin
            clear_obs();
            if (c == 0) begin
                build_exp(10, 13, 2, 0, 3, 3, 3, 3, 3, 3, 1'b0, n);
                send_insn(10, 13, 2, 0, 3, 3, 3, 3, 3, 3, 1'b0, t);
            end else begin
                build_exp(10, 10, 2, 3, 3, 3, 3, 3, 3, 3, 1'b0, n);
                send_insn(10, 10, 2, 3, 3, 3, 3, 3, 3, 3, 1'b0, t);
            end
            @(negedge clk);
            n_vec++;
            if ({insn_done, insn_ready, u_valid, uop_rd_en} !== 4'b1000) begin
                n_err++;
                $display("FAIL empty%0d_t1: got done/rdy/val/rden=%b at %0d, required 1000 at %0d",
                         c, {insn_done, insn_ready, u_valid, uop_rd_en}, cyc, t + 1);
            end
            wait_ready(tr);
            n_vec++;
            if (tr != t + 2 || n != 0 || rd_cnt != 0 || vcyc_q.size() != 0 || done_q.size() != 1) begin
                n_err++;
                $display("FAIL empty%0d_tail: ready at %0d reads %0d outs %0d dones %0d, required %0d/0/0/1",
                         c, tr, rd_cnt, vcyc_q.size(), done_q.size(), t + 2);
            end
        end
    endtask

    task automatic test_wrap();
        int t, tr, n;
        clear_obs();
        build_exp(100, 101, 1, 4, 5, 'h7FF, 9, 'h7FF, 3, 'h3FF, 1'b1, n);
        send_insn(100, 101, 1, 4, 5, 'h7FF, 9, 'h7FF, 3, 'h3FF, 1'b1, t);
        wait_ready(tr);
        n_vec++;
        if (vcyc_q.size() != n || done_q.size() != 1 || done_q[0] != t + n + 1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL wrap_count: got %0d outputs, %0d dones, %0d left, required %0d, 1, 0",
                     vcyc_q.size(), done_q.size(), exp_q.size(), n);
        end
    endtask

    task automatic test_mid_reset();
        int t, tr, n, k;
        int f[6];
        for (int j = 0; j < 6; j++) f[j] = $urandom_range(0, 1023);
        clear_obs();
        build_exp(20, 23, 3, 2, f[0], f[1], f[2], f[3], f[4], f[5], 1'b1, n);
        send_insn(20, 23, 3, 2, f[0], f[1], f[2], f[3], f[4], f[5], 1'b1, t);
        k = 0;
        while (vcyc_q.size() < 5 && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        n_vec++;
        if (vcyc_q.size() != 5) begin
            n_err++;
            $display("FAIL midrst_pre: got %0d outputs before reset, required 5", vcyc_q.size());
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({u_valid, insn_ready, insn_done, u_last, u_reset} !== 5'b01000) begin
            n_err++;
            $display("FAIL midrst_after: got val/rdy/done/last/rst=%b, required 01000",
                     {u_valid, insn_ready, insn_done, u_last, u_reset});
        end
        exp_q.delete();
        repeat (20) @(negedge clk);
        n_vec++;
        if (done_q.size() != 0 || vcyc_q.size() != 5) begin
            n_err++;
            $display("FAIL midrst_quiet: got %0d dones, %0d outputs, required 0 and 5",
                     done_q.size(), vcyc_q.size());
        end
        clear_obs();
        build_exp(4, 6, 2, 3, f[1], f[0], f[3], f[2], f[5], f[4], 1'b0, n);
        send_insn(4, 6, 2, 3, f[1], f[0], f[3], f[2], f[5], f[4], 1'b0, t);
        wait_ready(tr);
        n_vec++;
        if (vcyc_q.size() != n || exp_q.size() != 0 || done_q.size() != 1) begin
            n_err++;
            $display("FAIL midrst_next: got %0d outputs, %0d left, %0d dones, required %0d, 0, 1",
                     vcyc_q.size(), exp_q.size(), done_q.size(), n);
        end
    endtask

    task automatic test_back_to_back();
        int ta, tb, tr, na, nb, k;
        clear_obs();
        build_exp(30, 33, 2, 2, 7, 5, 6, 4, 3, 2, 1'b1, na);
        build_exp(40, 42, 1, 3, 1, 9, 2, 8, 3, 7, 1'b0, nb);
        @(negedge clk);
        drive_fields(30, 33, 2, 2, 7, 5, 6, 4, 3, 2, 1'b1);
        insn_valid = 1'b1;
        @(posedge clk);
        #1;
        ta = cyc - 1;
        // Second instruction is offered continuously while the first runs.
        drive_fields(40, 42, 1, 3, 1, 9, 2, 8, 3, 7, 1'b0);
        tb = -1;
        k  = 0;
        while (tb < 0 && k < 500) begin
            @(negedge clk);
            if (insn_ready) tb = cyc;
            k++;
        end
        @(posedge clk);
        #1 insn_valid = 1'b0;
        wait_ready(tr);
        n_vec++;
        if (done_q.size() < 1 || tb != done_q[0] + 1 || tb != ta + na + 2) begin
            n_err++;
            $display("FAIL b2b_accept: got second accept at %0d, first done at %0d, required %0d",
                     tb, (done_q.size() > 0) ? done_q[0] : -1, ta + na + 2);
        end
        n_vec++;
        if (vcyc_q.size() != na + nb || done_q.size() != 2 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_count: got %0d outputs, %0d dones, %0d left, required %0d, 2, 0",
                     vcyc_q.size(), done_q.size(), exp_q.size(), na + nb);
        end
        n_vec++;
        if (done_q.size() != 2 || done_q[1] != tb + nb + 1) begin
            n_err++;
            $display("FAIL b2b_done2: got %0d, required %0d",
                     (done_q.size() > 1) ? done_q[1] : -1, tb + nb + 1);
        end
    endtask

    task automatic test_random();
        int t, n, k, bgn, len, io, ii;
        int f[6];
        bit rf;
        for (int it = 0; it < 8; it++) begin
            bgn = $urandom_range(0, 8000);
            len = $urandom_range(1, 4);
            io  = $urandom_range(1, 3);
            ii  = $urandom_range(1, 3);
            rf  = 1'($urandom_range(0, 1));
            f[0] = $urandom_range(0, 2047);
            f[1] = $urandom_range(0, 2047);
            f[2] = $urandom_range(0, 2047);
            f[3] = $urandom_range(0, 2047);
            f[4] = $urandom_range(0, 1023);
            f[5] = $urandom_range(0, 1023);
            clear_obs();
            build_exp(bgn, bgn + len, io, ii, f[0], f[1], f[2], f[3], f[4], f[5], rf, n);
            send_insn(bgn, bgn + len, io, ii, f[0], f[1], f[2], f[3], f[4], f[5], rf, t);
            k = 0;
            while (k < 600) begin
                u_stall = ($urandom_range(0, 3) == 0);
                @(posedge clk);
                #1;
                k++;
                if (insn_ready) break;
            end
            u_stall = 1'b0;
            @(negedge clk);
            n_vec++;
            if (vcyc_q.size() != n || rd_cnt != n || done_q.size() != 1 || exp_q.size() != 0 ||
                done_q[0] != vcyc_q[vcyc_q.size() - 1]) begin
                n_err++;
                $display("FAIL rand%0d: got %0d outputs %0d reads %0d dones %0d left, required %0d/%0d/1/0",
                         it, vcyc_q.size(), rd_cnt, done_q.size(), exp_q.size(), n, n);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst        = 1'b1;
        insn_valid = 1'b0;
        u_stall    = 1'b0;
        drive_fields(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        test_reset();
        test_basic();
        test_stall();
        test_empty();
        test_wrap();
        test_mid_reset();
        test_back_to_back();
        test_random();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
